// File: rtl/dequeue_block_unpacker.sv
// -----------------------------------------------------------------------------
// dequeue_block_unpacker
//
// Receive-side message unpacker for the serial link. One physical transfer of
// NumDatBlocks blocks is accepted at a time. Bit 0 of each block is a control
// bit that marks the first block of a message. The transfer is split back into
// its messages, and one message is presented per output handshake. Each
// message is right-aligned to block 0 with its control bits removed.
//
// Optional feature (compile-time macro DEQUEUE_BLOCK_UNPACKER_DROP_CNT_EN):
//   defined   -> drop_cnt_o is a 16-bit saturating count of discarded blocks.
//                Discarded blocks are the leading padding in front of the first
//                start bit, or a whole window that contains no start bit.
//   undefined -> drop_cnt_o is tied to zero and no counter is built.
//
// Ports:
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset
//   valid_i       in   input transfer valid
//   ready_o       out  input transfer accepted when valid_i && ready_o
//   data_i        in   NumDatBlocks*BlockSize, block k at [k*BlockSize +: BlockSize]
//   num_splits_i  in   splits used; window L = min(max(n,1)*ClkDiv, NumDatBlocks)
//   valid_o       out  message valid
//   ready_i       in   message consumed
//   data_o        out  NumDatBlocks*(BlockSize-1), message payload, zero above it
//   num_blocks_o  out  number of blocks in the current message
//   drop_cnt_o    out  16-bit discarded-block count (see optional feature)
// -----------------------------------------------------------------------------
module dequeue_block_unpacker #(
    parameter int unsigned  ClkDiv                    = 1,
    parameter int unsigned  MaxPossibleTransferSplits = 1,
    parameter int unsigned  BlockSize                 = 9,
    parameter bit           AllowVarAxisLen           = 1'b1,
    parameter type          split_cntr_t              = logic,
    localparam int unsigned NumDatBlocks              = ClkDiv * MaxPossibleTransferSplits,
    localparam int unsigned PayW                      = BlockSize - 1,
    localparam int unsigned CntW                      = $clog2(NumDatBlocks + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [NumDatBlocks*BlockSize-1:0]   data_i,
    input  logic [$bits(split_cntr_t)-1:0]      num_splits_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [NumDatBlocks*PayW-1:0]        data_o,
    output logic [CntW-1:0]                     num_blocks_o,
    output logic [15:0]                         drop_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_e                            state_q, state_d;
    logic [NumDatBlocks*BlockSize-1:0] buf_q, buf_d;
    logic [CntW-1:0]                   lim_q, lim_d;
    logic [CntW-1:0]                   cur_q, cur_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [NumDatBlocks-1:0]      ctrl;        // control bit of every buffered block
    logic [NumDatBlocks*PayW-1:0] pay;         // buffered payloads, control bits stripped
    logic [NumDatBlocks*PayW-1:0] pay_shift;   // payloads moved down so block s sits at 0
    logic [CntW-1:0]              lim_in;      // window length of the incoming transfer
    logic [31:0]                  splits_eff;
    logic [31:0]                  blocks_req;
    logic                         has_start;   // a start bit exists in [cur_q, L)
    logic                         found_end;
    logic [CntW-1:0]              start_idx;
    logic [CntW-1:0]              end_idx;
    logic [CntW-1:0]              msg_len;
    logic                         last_msg;
    logic                         msg_hs;
    logic                         accept;

    // Split the buffer into control bits and payload fields.
    for (genvar gi = 0; gi < NumDatBlocks; gi++) begin : g_split
        assign ctrl[gi]                = buf_q[gi*BlockSize];
        assign pay[gi*PayW +: PayW]    = buf_q[gi*BlockSize + 1 +: PayW];
    end

    // Window length of the incoming transfer. A split count of zero is
    // treated as one split, and the product is capped at the physical width.
    always_comb begin
        splits_eff = 32'(num_splits_i);
        if (splits_eff == 32'd0) begin
            splits_eff = 32'd1;
        end
        blocks_req = splits_eff * ClkDiv;
        if (blocks_req > NumDatBlocks) begin
            blocks_req = NumDatBlocks;
        end
        lim_in = CntW'(blocks_req);
    end

    // Locate the current message: s is the first start bit at or after cur_q,
    // e is the next start bit after s (or the window end). In fixed-length
    // mode the whole window is a single message and control bits are ignored.
    always_comb begin
        has_start = 1'b0;
        found_end = 1'b0;
        start_idx = '0;
        end_idx   = lim_q;
        if (AllowVarAxisLen) begin
            for (int k = 0; k < NumDatBlocks; k++) begin
                if (!has_start && (CntW'(k) >= cur_q) && (CntW'(k) < lim_q) && ctrl[k]) begin
                    has_start = 1'b1;
                    start_idx = CntW'(k);
                end
            end
            for (int k = 0; k < NumDatBlocks; k++) begin
                if (has_start && !found_end && (CntW'(k) > start_idx) &&
                    (CntW'(k) < lim_q) && ctrl[k]) begin
                    found_end = 1'b1;
                    end_idx   = CntW'(k);
                end
            end
        end else begin
            has_start = 1'b1;
        end
    end

    assign msg_len  = end_idx - start_idx;
    assign last_msg = (end_idx == lim_q);

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign valid_o = (state_q == EMIT) && has_start;
    assign msg_hs  = valid_o && ready_i;
    // Taking the next transfer on the last message's handshake removes the
    // idle bubble between back-to-back transfers.
    assign ready_o = (state_q == IDLE) || (msg_hs && last_msg);
    assign accept  = valid_i && ready_o;

    // -------------------------------------------------------------------------
    // Output data: shift the selected message to block 0 and blank everything
    // above its length. Only registered state feeds these paths.
    // -------------------------------------------------------------------------
    assign pay_shift = pay >> (32'(start_idx) * PayW);

    for (genvar gi = 0; gi < NumDatBlocks; gi++) begin : g_out
        assign data_o[gi*PayW +: PayW] = (valid_o && (CntW'(gi) < msg_len)) ?
                                         pay_shift[gi*PayW +: PayW] : '0;
    end

    assign num_blocks_o = valid_o ? msg_len : '0;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        lim_d   = lim_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            EMIT: begin
                if (!has_start) begin
                    // Nothing left to send: the rest of the window is dropped.
                    state_d = IDLE;
                    cur_d   = '0;
                end else if (msg_hs) begin
                    if (last_msg) begin
                        state_d = IDLE;
                        cur_d   = '0;
                    end else begin
                        cur_d = end_idx;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cur_d   = '0;
            end
        endcase
        // A new transfer overrides the return to IDLE above.
        if (accept) begin
            buf_d   = data_i;
            lim_d   = lim_in;
            cur_d   = '0;
            state_d = EMIT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
            lim_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            lim_q   <= lim_d;
            cur_q   <= cur_d;
        end
    end

    // -------------------------------------------------------------------------
    // Discarded-block counter
    // -------------------------------------------------------------------------
`ifdef DEQUEUE_BLOCK_UNPACKER_DROP_CNT_EN
    logic [CntW-1:0] drop_blocks;
    logic [16:0]     drop_sum;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    // Leading padding is counted on the handshake that consumes its message,
    // so a stalled message does not count its padding more than once.
    always_comb begin
        drop_blocks = '0;
        if (state_q == EMIT) begin
            if (!has_start) begin
                drop_blocks = lim_q - cur_q;
            end else if (msg_hs) begin
                drop_blocks = start_idx - cur_q;
            end
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_blocks);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

    // -------------------------------------------------------------------------
    // Simulation-only checks
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    logic                         chk_hold_q;
    logic [NumDatBlocks*PayW-1:0] chk_data_q;
    logic [CntW-1:0]              chk_len_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_hold_q <= 1'b0;
            chk_data_q <= '0;
            chk_len_q  <= '0;
        end else begin
            if (chk_hold_q) begin
                assert (data_o == chk_data_q && num_blocks_o == chk_len_q)
                    else $error("message changed while stalled");
            end
            assert (cur_q <= lim_q)
                else $error("cur_q beyond window");
            if (valid_o) begin
                assert (num_blocks_o != '0)
                    else $error("empty message presented");
            end
            chk_hold_q <= valid_o && !ready_i;
            chk_data_q <= data_o;
            chk_len_q  <= num_blocks_o;
        end
    end
`endif

endmodule

// File: tb/tb_dequeue_block_unpacker.sv
// -----------------------------------------------------------------------------
// Testbench for dequeue_block_unpacker with ClkDiv=4, one split, 9-bit blocks.
// A reference model turns each transfer into its list of messages (start bits
// in the window, each message runs to the next start bit or the window end)
// and the expected discarded-block total. Directed transfers cover the listed
// scenarios, followed by random transfers with random consumer stalls.
// -----------------------------------------------------------------------------
module tb_dequeue_block_unpacker;

    localparam int ClkDiv = 4;
    localparam int NBlk   = 4;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic        valid_i      = 1'b0;
    logic        ready_i      = 1'b0;
    logic [35:0] data_i       = '0;
    logic [0:0]  num_splits_i = 1'b1;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic [2:0]  num_blocks_o;
    logic [15:0] drop_cnt_o;

    int          checks    = 0;
    int          errors    = 0;
    int          exp_drops = 0;

    always #5 clk_i = ~clk_i;

    dequeue_block_unpacker #(
        .ClkDiv                   (ClkDiv),
        .MaxPossibleTransferSplits(1),
        .BlockSize                (9),
        .AllowVarAxisLen          (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .num_splits_i(num_splits_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .num_blocks_o(num_blocks_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected drop counter value as seen on drop_cnt_o in this build.
    function automatic logic [15:0] drop_view();
`ifdef DEQUEUE_BLOCK_UNPACKER_DROP_CNT_EN
        return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
        return 16'h0000;
`endif
    endfunction

    // Send one transfer and consume all of its messages. 'hold' stalls the
    // first message for that many cycles; 'rnd' adds random stalls.
    task automatic do_transfer(input string name, input logic [31:0] pay_bytes,
                               input logic [3:0] ctrl_bits, input logic [0:0] ns,
                               input int hold, input bit rnd);
        int          lim;
        int          starts[$];
        int          s;
        int          e;
        int          last;
        bit          done;
        logic [35:0] d;
        logic [31:0] exp_data;

        // Reference model
        lim = ((ns == 1'b0) ? 1 : int'(ns)) * ClkDiv;
        if (lim > NBlk) lim = NBlk;
        for (int k = 0; k < lim; k++) begin
            if (ctrl_bits[k]) starts.push_back(k);
        end
        if (starts.size() == 0) exp_drops += lim;
        else                    exp_drops += starts[0];
        for (int k = 0; k < NBlk; k++) begin
            d[k*9 +: 9] = {pay_bytes[k*8 +: 8], ctrl_bits[k]};
        end
        last = starts.size() - 1;

        @(negedge clk_i);
        valid_i      = 1'b1;
        data_i       = d;
        num_splits_i = ns;
        ready_i      = 1'b0;
        #1;
        chk({name, " in_ready"}, 64'(ready_o), 64'd1);
        @(posedge clk_i);

        if (starts.size() == 0) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            #1;
            chk({name, " nostart_valid"}, 64'(valid_o), 64'd0);
            chk({name, " nostart_ready"}, 64'(ready_o), 64'd0);
            @(posedge clk_i);
        end else begin
            for (int m = 0; m < starts.size(); m++) begin
                s = starts[m];
                e = (m + 1 < starts.size()) ? starts[m+1] : lim;
                exp_data = '0;
                for (int j = 0; j < e - s; j++) begin
                    exp_data = exp_data | (32'(pay_bytes[(s+j)*8 +: 8]) << (8*j));
                end
                done = 1'b0;
                for (int c = 0; c < 40 && !done; c++) begin
                    @(negedge clk_i);
                    valid_i = 1'b0;
                    if (m == 0 && c < hold)  ready_i = 1'b0;
                    else if (rnd && c < 20) ready_i = ($urandom_range(0, 99) < 60);
                    else                    ready_i = 1'b1;
                    #1;
                    chk({name, " msg_valid"},   64'(valid_o),      64'd1);
                    chk({name, " msg_data"},    64'(data_o),       64'(exp_data));
                    chk({name, " msg_blocks"},  64'(num_blocks_o), 64'(e - s));
                    chk({name, " msg_ready_o"}, 64'(ready_o),      64'(ready_i && (m == last)));
                    @(posedge clk_i);
                    if (ready_i) done = 1'b1;
                end
            end
        end

        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        chk({name, " idle_valid"}, 64'(valid_o),    64'd0);
        chk({name, " idle_ready"}, 64'(ready_o),    64'd1);
        chk({name, " drop_cnt"},   64'(drop_cnt_o), 64'(drop_view()));
        $display("transfer %s ctrl=%b ns=%0d messages=%0d drops_total=%0d",
                 name, ctrl_bits, ns, starts.size(), exp_drops);
    endtask

    initial begin
        // Reset state
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst valid_o",      64'(valid_o),      64'd0);
        chk("rst data_o",       64'(data_o),       64'd0);
        chk("rst num_blocks_o", 64'(num_blocks_o), 64'd0);
        chk("rst drop_cnt_o",   64'(drop_cnt_o),   64'd0);
        rst_ni = 1'b1;
        #1;
        chk("rst ready_o",      64'(ready_o),      64'd1);

        // Directed scenarios
        do_transfer("two_msgs",   32'hA3A2A1A0, 4'b0101, 1'b1, 0, 1'b0);
        do_transfer("single",     32'hA3A2A1A0, 4'b0001, 1'b1, 0, 1'b0);
        do_transfer("padding",    32'hA3A2A1A0, 4'b0100, 1'b1, 0, 1'b0);
        do_transfer("no_start",   32'hA3A2A1A0, 4'b0000, 1'b1, 0, 1'b0);
        do_transfer("backpress",  32'hA3A2A1A0, 4'b0101, 1'b1, 5, 1'b0);
        do_transfer("splits_0",   32'h5A6B7C8D, 4'b1011, 1'b0, 1, 1'b0);
        do_transfer("each_block", 32'h11223344, 4'b1111, 1'b1, 0, 1'b0);

        // Back-to-back transfers, one message per cycle
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = {8'hA3, 1'b0, 8'hA2, 1'b0, 8'hA1, 1'b0, 8'hA0, 1'b1};
        ready_i = 1'b1;
        num_splits_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        data_i = {8'hB3, 1'b0, 8'hB2, 1'b0, 8'hB1, 1'b0, 8'hB0, 1'b1};
        #1;
        chk("b2b first_valid", 64'(valid_o), 64'd1);
        chk("b2b first_data",  64'(data_o),  64'hA3A2A1A0);
        chk("b2b first_ready", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        chk("b2b second_valid", 64'(valid_o), 64'd1);
        chk("b2b second_data",  64'(data_o),  64'hB3B2B1B0);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("b2b idle_valid", 64'(valid_o), 64'd0);
        chk("b2b idle_ready", 64'(ready_o), 64'd1);
        $display("transfer b2b two single-message transfers on consecutive cycles");

        // Reset in the middle of a stalled transfer
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = {8'hC3, 1'b0, 8'hC2, 1'b1, 8'hC1, 1'b0, 8'hC0, 1'b1};
        ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        chk("midrst before_valid", 64'(valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("midrst during_valid", 64'(valid_o), 64'd0);
        exp_drops = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("midrst after_valid", 64'(valid_o),    64'd0);
        chk("midrst after_ready", 64'(ready_o),    64'd1);
        chk("midrst after_drop",  64'(drop_cnt_o), 64'd0);
        $display("transfer midrst reset while a message was stalled");

        // Random transfers with random stalls
        for (int t = 0; t < 30; t++) begin
            do_transfer($sformatf("rand%0d", t), 32'($urandom),
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dequeue_block_unpacker.md
Name: dequeue_block_unpacker

Overview:
- Receive-side counterpart of the transmit-side message packer in the serial link.
- Accepts one physical transfer made of NumDatBlocks blocks. Bit 0 of each block is a block control bit: 1 = first block of a message.
- Splits the transfer back into the individual messages and emits one message per output handshake, right-aligned to block 0 and with control bits stripped.
- Sits between the link's deserialising physical layer and the AXIS/network-layer receive path.

Parameters:
- ClkDiv, 1, clock division of the link; sets the number of blocks per split.
- MaxPossibleTransferSplits, 1, maximum number of splits per transfer.
- BlockSize, 9, block width in bits, including the control bit.
- AllowVarAxisLen, 1'b1, 1 = multiple messages per transfer are decoded. 0 = every transfer is one message starting at block 0, and control bits are ignored.
- split_cntr_t, logic, type of num_splits_i.
- NumDatBlocks (localparam), ClkDiv*MaxPossibleTransferSplits.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input transfer valid.
- ready_o  out  1  input transfer accepted when valid_i && ready_o.
- data_i  in  NumDatBlocks*BlockSize  blocks; block k occupies bits [k*BlockSize +: BlockSize]; bit 0 of each block is the control bit.
- num_splits_i  in  $bits(split_cntr_t)  splits used. Valid block limit L = min(num_splits_i*ClkDiv, NumDatBlocks). A value of 0 is treated as 1.
- valid_o  out  1  message valid.
- ready_i  in  1  message consumed.
- data_o  out  NumDatBlocks*(BlockSize-1)  message payload; block j at [j*(BlockSize-1) +: BlockSize-1]; zero above the message.
- num_blocks_o  out  $clog2(NumDatBlocks+1)  number of blocks in the current message.
- drop_cnt_o  out  16  count of discarded blocks (see Optional Feature).

Behaviour:
- Storage:
  - Buffer register holds one transfer plus L.
  - Pointer cur_q in [0, NumDatBlocks].
  - FSM with two states, IDLE and EMIT.
- Reset values: FSM = IDLE; cur_q = 0; buffer = 0; valid_o = 0; data_o = 0; num_blocks_o = 0; drop_cnt_o = 0. ready_o = 1 once out of reset.
- IDLE:
  - ready_o = 1.
  - On valid_i handshake: latch data_i and L, set cur_q = 0, go to EMIT.
  - Latency: first valid_o is asserted the cycle after input acceptance.
- EMIT, start position:
  - s = lowest index >= cur_q with control bit 1 and index < L.
  - Blocks in cur_q..s-1 are discarded (leading padding) and added to the drop count.
  - If no such s exists: all remaining blocks are dropped, and the FSM returns to IDLE with no output that cycle.
- EMIT, end position:
  - e = lowest index > s with control bit 1 and index < L; otherwise e = L.
  - Trailing blocks with control bit 0 belong to the preceding message.
- EMIT, outputs:
  - valid_o = 1.
  - data_o = blocks s..e-1 moved to positions 0..e-s-1, control bits removed, upper part zero.
  - num_blocks_o = e-s.
  - All outputs are combinational from registered state only; no path from ready_i to data_o.
- EMIT, advance:
  - On valid_o && ready_i, set cur_q = e.
  - If e == L, this is the last message. ready_o is driven to 1 in that same cycle (ready_o = in IDLE, or last-message handshake). A new input may be latched simultaneously, giving back-to-back throughput with no bubble. If no new input arrives, go to IDLE.
- Backpressure: while valid_o && !ready_i, data_o, num_blocks_o and cur_q are held stable, and ready_o = 0 (unless in IDLE).
- Messages never span transfers. Any remainder past L is ignored and not counted as dropped.
- AllowVarAxisLen = 0: exactly one message per transfer, with s = 0, e = L; no drops.
- Reset mid-operation: the buffered transfer is lost and the block returns immediately to IDLE reset values.
- Assertions, all under simulation:
  - data_o stable while valid_o && !ready_i.
  - cur_q <= L.
  - num_blocks_o != 0 whenever valid_o.

Optional Feature:
- Macro: DEQUEUE_BLOCK_UNPACKER_DROP_CNT_EN.
- Defined:
  - drop_cnt_o is a 16-bit saturating counter (stops at 16'hFFFF).
  - It is incremented by the number of blocks discarded per cycle: leading padding, or all remaining blocks of a transfer with no start bit.
  - Reset to 0.
- Undefined: drop_cnt_o is tied to 0 and no counter logic is generated.

Test Plan:
All scenarios use ClkDiv=4, MaxPossibleTransferSplits=1, BlockSize=9 (data_i 36 bits, data_o 32 bits), payload bytes A0..A3 in blocks 0..3.
- Two messages: control bits (block 3..0) = 0101, num_splits_i=1 -> data_o 0x0000A1A0 with num_blocks_o=2, then 0x0000A3A2 with num_blocks_o=2, then IDLE.
- Single full message: control 0001 -> one output 0xA3A2A1A0, num_blocks_o=4.
- Leading padding: control 0100 -> one output 0x0000A3A2, num_blocks_o=2; with macro, drop_cnt_o goes 0 -> 2.
- No start bit: control 0000 -> no valid_o; ready_o back to 1 the next cycle; with macro, drop_cnt_o increments by 4.
- Backpressure: control 0101, ready_i=0 for 5 cycles -> first message held stable with ready_o=0; after ready_i=1, second message is emitted the next cycle.
- Back-to-back: two transfers (control 0001 each) with valid_i and ready_i held 1 -> valid_o high on consecutive cycles, one message per cycle. Assert rst_ni low mid-stream -> valid_o=0 and ready_o=1 after release.
